// File: rtl/logic_stim_pkg.sv
// Shared types and golden response for the logic sample-block stimulus checker.
package logic_stim_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int NUM_VEC = 8;
  localparam int VEC_W   = 3;

  // Expected {x,y,z} for vector {a,b,c}; c does not influence the sample block.
  function automatic logic [2:0] exp_resp(input logic [VEC_W-1:0] vec, input logic prev_or);
    logic a, b;
    a = vec[2];
    b = vec[1];
    return {a | b, a & b, prev_or & (a | b)};
  endfunction

endpackage

// File: rtl/logic_stim_checker_ref_model.sv
// Golden model for the sample block: registered prev_or history plus the
// combinational expected-response function.
module stim_ref_model
  import logic_stim_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             upd_i,
  input  logic [VEC_W-1:0] vec_i,
  output logic [2:0]       exp_o
);

  logic r_prev_or;
  logic [2:0] w_exp;

  assign w_exp = exp_resp(vec_i, r_prev_or);
  assign exp_o = w_exp;

  // prev_or advances once per compare so the next vector sees this one's x|y.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)     r_prev_or <= 1'b0;
    else if (clr_i) r_prev_or <= 1'b0;
    else if (upd_i) r_prev_or <= w_exp[2] | w_exp[1];
  end

endmodule

// File: rtl/logic_stim_checker.sv
// Stimulus/checker FSM: walks all 8 {a,b,c} vectors into the sample block and
// checks {x,y,z} LAT cycles later. Define STOP_ON_ERR_EN to halt on first mismatch.
module logic_stim_checker
  import logic_stim_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int ERR_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             en_o,
  output logic             a_o,
  output logic             b_o,
  output logic             c_o,
  input  logic             x_i,
  input  logic             y_i,
  input  logic             z_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [2:0]       fail_vec_o
);

  localparam logic [3:0] LAT_C = 4'(LAT);

  state_t           r_state, w_next;
  logic [VEC_W-1:0] r_vec_cnt, r_abc, r_fail_vec;
  logic [3:0]       r_wait_cnt;
  logic [ERR_W-1:0] r_err_cnt;
  logic [2:0]       w_exp;
  logic             w_start, w_cmp, w_mis, w_stop, w_last;

  stim_ref_model u_ref (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (w_start),
    .upd_i (w_cmp),
    .vec_i (r_abc),
    .exp_o (w_exp)
  );

  always_comb begin
    w_start = ((r_state == S_IDLE) || (r_state == S_DONE)) && start_i;
    w_cmp   = (r_state == S_WAIT) && (r_wait_cnt == LAT_C);
    w_mis   = w_cmp && ({x_i, y_i, z_i} != w_exp);
    w_last  = (r_vec_cnt == VEC_W'(NUM_VEC - 1));
`ifdef STOP_ON_ERR_EN
    w_stop  = w_mis;
`else
    w_stop  = 1'b0;
`endif
    w_next  = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_start) w_next = S_LOAD;
      S_LOAD:         w_next = S_WAIT;
      S_WAIT:         if (w_cmp) w_next = (w_last || w_stop) ? S_DONE : S_LOAD;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_vec_cnt  <= '0;
      r_abc      <= '0;
      r_wait_cnt <= '0;
      r_err_cnt  <= '0;
      r_fail_vec <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_vec_cnt  <= '0;
        r_err_cnt  <= '0;
        r_fail_vec <= '0;
      end
      case (r_state)
        S_LOAD: begin
          r_abc      <= r_vec_cnt;
          r_wait_cnt <= 4'd1;
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 4'd1;
          if (w_cmp) begin
            if (w_mis) begin
              if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
              // Counter is cleared per run and never returns to zero, so zero marks the first error.
              if (r_err_cnt == '0) r_fail_vec <= r_vec_cnt;
            end
            if (!w_last && !w_stop) r_vec_cnt <= r_vec_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign en_o       = (r_state == S_LOAD) || (r_state == S_WAIT);
  assign busy_o     = en_o;
  assign done_o     = (r_state == S_DONE);
  assign pass_o     = done_o && (r_err_cnt == '0);
  assign {a_o, b_o, c_o} = r_abc;
  assign err_cnt_o  = r_err_cnt;
  assign fail_vec_o = r_fail_vec;

endmodule

// File: tb/tb_logic_stim_checker.sv
// Randomized bench for logic_stim_checker with a timeline-based model and a
// behavioural sample block that can be made faulty.
module tb_logic_stim_checker;

  localparam int LAT = 2;
  localparam int P   = LAT + 1;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, start2 = 1'b0;
  logic en, a, b, c, busy, done, pass;
  logic [3:0] err;
  logic [2:0] fv;
  logic x = 1'b0, y = 1'b0, z = 1'b0;
  logic en2, a2, b2, c2, busy2, done2, pass2;
  logic [1:0] err2;
  logic [2:0] fv2;
  logic x2 = 1'b0, y2 = 1'b0, z2 = 1'b0;

  int mode = 0;
  int nvec = 0, nfail = 0;
  bit active = 1'b0;
  int n = 0, end_n = 0, lastv = 7, old_abc = 0, cur_abc = 0, run_mode = 0, runs = 0;
  bit mis[8];

`ifdef STOP_ON_ERR_EN
  int lit_end[3] = '{24, 9, 3};
  int lit_err[3] = '{0, 1, 1};
  int lit_abc[3] = '{7, 2, 0};
  int lit_err2   = 1;
`else
  int lit_end[3] = '{24, 24, 24};
  int lit_err[3] = '{0, 6, 3};
  int lit_abc[3] = '{7, 7, 7};
  int lit_err2   = 3;
`endif
  int lit_fv[3]   = '{0, 2, 0};
  int lit_pass[3] = '{1, 0, 0};

  logic_stim_checker #(.LAT(LAT), .ERR_W(4)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .en_o(en),
    .a_o(a), .b_o(b), .c_o(c), .x_i(x), .y_i(y), .z_i(z),
    .busy_o(busy), .done_o(done), .pass_o(pass), .err_cnt_o(err), .fail_vec_o(fv)
  );

  logic_stim_checker #(.LAT(LAT), .ERR_W(2)) u_sat (
    .clk_i(clk), .rst_i(rst_n), .start_i(start2), .en_o(en2),
    .a_o(a2), .b_o(b2), .c_o(c2), .x_i(x2), .y_i(y2), .z_i(z2),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2), .err_cnt_o(err2), .fail_vec_o(fv2)
  );

  always #5 clk = ~clk;

  // Correct sample-block response while walking vectors 0..7 in order:
  // x set from vector 2 up, y only for 6/7, z once the previous vector also had a|b.
  function automatic logic [2:0] spec_resp(input int v);
    return {(v >= 2) ? 1'b1 : 1'b0, (v >= 6) ? 1'b1 : 1'b0, (v >= 3) ? 1'b1 : 1'b0};
  endfunction

  // 0 good, 1 x stuck-at-0, 2 z stuck-at-1, 3 all outputs inverted
  function automatic logic [2:0] dut_resp(input int v, input int m);
    logic [2:0] r;
    r = spec_resp(v);
    case (m)
      1: r[2] = 1'b0;
      2: r[0] = 1'b1;
      3: r = ~r;
      default: ;
    endcase
    return r;
  endfunction

  // Sample block with one register stage of its own.
  always @(posedge clk) begin
    {x, y, z}    <= dut_resp(int'({a, b, c}), mode);
    {x2, y2, z2} <= dut_resp(int'({a2, b2, c2}), 3);
  end

  task automatic chk(input string nm, input int act, input int expv);
    nvec++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic check_zero(input string nm);
    chk(nm, int'({en, busy, done, pass, a, b, c, err, fv}), 0);
  endtask

  task automatic model_start();
    int ff;
    ff = -1;
    for (int v = 0; v < 8; v++) begin
      mis[v] = (dut_resp(v, mode) != spec_resp(v));
      if (mis[v] && ff < 0) ff = v;
    end
    lastv = 7;
`ifdef STOP_ON_ERR_EN
    if (ff >= 0) lastv = ff;
`endif
    end_n    = (lastv + 1) * P;
    old_abc  = cur_abc;
    run_mode = mode;
    n        = 0;
    active   = 1'b1;
  endtask

  task automatic check_cycle();
    int eabc, eerr, efv, expv;
    bit erun, edone, epass;
    eabc = 0; eerr = 0; efv = 0; erun = 0; edone = 0; epass = 0;
    if (active) begin
      erun  = (n < end_n);
      edone = !erun;
      if (n == 0) eabc = old_abc;
      else        eabc = ((n - 1) / P < lastv) ? (n - 1) / P : lastv;
      for (int v = 0; v <= lastv; v++)
        if ((v + 1) * P <= n && mis[v]) begin
          if (eerr == 0) efv = v;
          if (eerr < 15) eerr++;
        end
      epass = edone && (eerr == 0);
    end
    cur_abc = eabc;
    expv = (int'(erun) << 13) | (int'(erun) << 12) | (int'(edone) << 11) | (int'(epass) << 10)
         | (eabc << 7) | (eerr << 3) | efv;
    chk("cycle{en,busy,done,pass,abc,err,fv}", int'({en, busy, done, pass, a, b, c, err, fv}), expv);
    if (active && n == lit_end[run_mode] - 1) chk("done_early", int'(done), 0);
    if (active && n == lit_end[run_mode]) begin
      chk("done_lit", int'(done), 1);
      chk("err_lit",  int'(err), lit_err[run_mode]);
      chk("fv_lit",   int'(fv), lit_fv[run_mode]);
      chk("pass_lit", int'(pass), lit_pass[run_mode]);
      chk("abc_lit",  int'({a, b, c}), lit_abc[run_mode]);
    end
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    check_zero(nm);
    active  = 1'b0;
    cur_abc = 0;
  endtask

  task automatic drive();
    if (!rst_n) begin
      rst_n = 1'b1;
      start = 1'b0;
    end else if (!active || n >= end_n) begin
      if (runs < 4 || $urandom_range(0, 3) == 0) begin
        mode  = (runs < 3) ? runs : (runs == 3) ? 0 : int'($urandom_range(0, 2));
        start = 1'b1;
        runs++;
      end else begin
        start = 1'b0;
      end
    end else begin
      start = ($urandom_range(0, 7) == 0);
      if (runs == 4 && n == 14)                    do_reset("rst_mid_vec4");
      else if (runs > 4 && $urandom_range(0, 299) == 0) do_reset("rst_random");
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check_zero("reset_main");
    chk("reset_sat", int'({en2, busy2, done2, pass2, a2, b2, c2, err2, fv2}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Saturating 2-bit counter with every vector mismatching.
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int i = 0; i < 60 && !done2; i++) @(negedge clk);
    chk("sat_done", int'(done2), 1);
    chk("sat_err",  int'(err2), lit_err2);
    chk("sat_fv",   int'(fv2), 0);
    chk("sat_pass", int'(pass2), 0);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      if (rst_n) begin
        if ((!active || n >= end_n) && start) model_start();
        else if (active) n++;
      end
      @(negedge clk);
      check_cycle();
      drive();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/logic_stim_checker.md
Name: logic_stim_checker

Overview:
- Active counterpart of the small combinational/registered logic sample blocks: drives the DUT's enable and 3-bit input vector {a,b,c}, then samples and checks its {x,y,z} responses.
- On start, walks all 8 input vectors, waits a parameterised DUT latency per vector, and compares against an internal reference model.
- Reports error count, first failing vector and pass/fail.
- Sits beside the DUT in the sample-block harness, on the same clock.

Parameters:
- LAT, 2: DUT input-to-output latency in clock cycles (legal range 1..15).
- ERR_W, 4: width of the saturating error counter.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- start_i  in  1  begin a run; sampled only in IDLE or DONE.
- en_o  out  1  DUT enable; high in LOAD and WAIT only.
- a_o  out  1  DUT input a (vector bit 2).
- b_o  out  1  DUT input b (vector bit 1).
- c_o  out  1  DUT input c (vector bit 0).
- x_i  in  1  DUT output x.
- y_i  in  1  DUT output y.
- z_i  in  1  DUT output z.
- busy_o  out  1  run in progress.
- done_o  out  1  run finished; level, held until next start or reset.
- pass_o  out  1  valid when done_o=1; 1 iff err_cnt_o==0.
- err_cnt_o  out  ERR_W  mismatching vectors; saturates at all-ones.
- fail_vec_o  out  3  first failing vector index; 0 if none.

Behaviour:
- Reset (rst_i=0, async): state IDLE. All outputs 0: en_o, a_o/b_o/c_o, busy_o, done_o, pass_o, err_cnt_o, fail_vec_o. Internal vec_cnt=0, wait_cnt=0, prev_or=0.
- FSM states: IDLE, LOAD, WAIT, DONE.
- IDLE/DONE, start_i=1: clear err_cnt_o, fail_vec_o, done_o, pass_o, vec_cnt, prev_or. Go to LOAD. busy_o=1 from next cycle.
- LOAD (1 cycle): register {a_o,b_o,c_o}=vec_cnt. en_o=1. wait_cnt=1. Go to WAIT.
- WAIT: wait_cnt increments each cycle. Compare {x_i,y_i,z_i} with expected on the edge where wait_cnt==LAT, i.e. LAT edges after the edge that updated a_o..c_o.
  - Per-vector period: LAT+1 cycles.
  - After compare: if vec_cnt==7, go to DONE; else vec_cnt+1 and go to LOAD.
- Reference model, computed from the applied vector:
  - exp_x = a|b
  - exp_y = a&b
  - exp_z = prev_or & (a|b), where prev_or = exp_x|exp_y of the previous vector (0 for vector 0).
  - prev_or updates at each compare.
- Mismatch (any bit differs): err_cnt_o increments, saturating. If this is the first error of the run, fail_vec_o=vec_cnt.
- DONE: en_o=0, busy_o=0, done_o=1, pass_o=(err_cnt_o==0). a_o..c_o hold the last vector.
- Total run: 8*(LAT+1) cycles from the LOAD entry to DONE entry.
- start_i during LOAD/WAIT: ignored.
- start_i held high in DONE: a new run starts immediately.
- Reset mid-run: immediate return to IDLE, results discarded.
- vec_cnt is 3 bits and never wraps within a run (terminates at 7).

Optional Feature:
- Macro: STOP_ON_ERR_EN.
- Defined: on the first mismatch the FSM goes directly to DONE after that compare. err_cnt_o=1, pass_o=0, fail_vec_o=failing vector, a_o..c_o hold the failing vector.
- Undefined: all 8 vectors always run; errors only accumulate.

Decomposition:
- Shared package logic_stim_pkg:
  - state enum typedef (IDLE, LOAD, WAIT, DONE);
  - NUM_VEC=8 and VEC_W=3 constants;
  - function exp_resp(vec, prev_or), returning {x,y,z}.
- One natural sub-module: stim_ref_model.
  - Registered prev_or plus the combinational expected-response function.
  - Instantiated once; keeps FSM and golden model separable for reuse by other sample-block checkers.

Test Plan:
- Correct behavioural DUT (LAT=2), pulse start_i -> done_o=1 after 24 cycles, pass_o=1, err_cnt_o=0, fail_vec_o=0. en_o high throughout busy.
- DUT with x stuck-at-0 -> err_cnt_o=6 (vectors 2..7), fail_vec_o=2, pass_o=0.
- DUT with z stuck-at-1 -> mismatches on vectors 0,1,2 -> err_cnt_o=3, fail_vec_o=0.
- rst_i low for 1 cycle during WAIT of vector 4 -> all outputs 0 asynchronously. A following start_i gives a fresh full run with correct results. start_i pulses mid-run have no effect.
- ERR_W=2, DUT inverting all outputs -> err_cnt_o saturates at 3, fail_vec_o=0.
- STOP_ON_ERR_EN defined, x stuck-at-0 -> DONE after vector 2 compare (9 cycles), err_cnt_o=1, fail_vec_o=2, {a_o,b_o,c_o}=3'b010.
